// File: rtl/am_audio_pkg.sv
// Shared definitions for the AM audio back end: FSM state encoding, gain
// limits (unsigned Q4.4) and the signed saturation helper.
package am_audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DC,
        ST_MUL,
        ST_SAT,
        ST_AGC
    } state_e;

    localparam logic [7:0] GAIN_UNITY = 8'd16;
    localparam logic [7:0] GAIN_MIN   = 8'd1;
    localparam logic [7:0] GAIN_MAX   = 8'd255;

    // Clamp v into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                     input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/am_audio_agc_mult.sv
// Sequential signed x unsigned shift-add multiplier, one multiplier bit per
// cycle, LSB first. start_i loads the operands; BW busy cycles follow and
// done_c is high during the last of them, so prod_o is final on the edge
// that ends the done_c cycle.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start_i     - load a_i/b_i and begin
//   a_i         - signed multiplicand, AW bits
//   b_i         - unsigned multiplier, BW bits
//   done_c      - combinational: current cycle is the final accumulate step
//   prod_o      - signed product, AW+BW bits (registered)
module shift_add_mult #(
    parameter int unsigned AW = 17,
    parameter int unsigned BW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic signed [AW-1:0] a_i,
    input  logic [BW-1:0]        b_i,
    output logic                 done_c,
    output logic signed [AW+BW-1:0] prod_o
);

    localparam int unsigned PW = AW + BW;
    localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

    logic signed [PW-1:0] mcand_q, mcand_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic [BW-1:0]        mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    assign done_c = busy_q && (cnt_q == CW'(BW - 1));
    assign prod_o = prod_q;

    // Next-state: load on start, otherwise add shifted multiplicand per bit.
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = PW'(a_i);
            mplier_d = b_i;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/am_audio_agc.sv
// AM audio back end: DC removal by leaky integrator, AGC gain via an 8-cycle
// shift-add multiply, saturation to a signed BITS_OUT sample.
// Ports:
//   CLK, RSTb  - clock, async active-low reset
//   demod_in   - unsigned envelope magnitude, valid with in_tick
//   in_tick    - input sample strobe (dropped unless idle)
//   audio_out  - saturated signed audio sample
//   out_tick   - one-cycle strobe when audio_out/gain_out update
//   gain_out   - current gain, unsigned Q4.4
//   overrun    - one-cycle pulse after a dropped in_tick
module am_audio_agc
    import am_audio_pkg::*;
#(
    parameter int unsigned BITS         = 16,
    parameter int unsigned BITS_OUT     = 8,
    parameter int unsigned DC_SHIFT     = 10,
    parameter int unsigned TARGET       = 24576,
    parameter int unsigned HOLD_SAMPLES = 2048
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic [BITS-1:0]            demod_in,
    input  logic                       in_tick,
    output logic signed [BITS_OUT-1:0] audio_out,
    output logic                       out_tick,
    output logic [7:0]                 gain_out,
    output logic                       overrun
);

    localparam int unsigned OSH = BITS + 1 - BITS_OUT;
    localparam int unsigned AW  = BITS + DC_SHIFT;
    localparam int unsigned YW  = BITS + 1;
    localparam int unsigned PW  = BITS + 9;
    localparam int unsigned ZW  = PW - 4;
    localparam int unsigned SW  = ZW - OSH;
    localparam int unsigned HW  = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    state_e                     state_q, state_d;
    logic [BITS-1:0]            x_q, x_d;
    logic [AW-1:0]              acc_q, acc_d;
    logic                       seed_q, seed_d;
    logic signed [BITS_OUT-1:0] s_q, s_d;
    logic                       over_q, over_d;
    logic [7:0]                 gain_q, gain_d;
    logic [HW-1:0]              hold_q, hold_d;
    logic signed [BITS_OUT-1:0] audio_q, audio_d;
    logic                       out_tick_q, out_tick_d;
    logic                       overrun_q, overrun_d;

    logic [BITS-1:0]            avg_c;
    logic signed [YW-1:0]       y_c;
    logic                       mult_done_c;
    logic signed [PW-1:0]       prod;
    logic signed [ZW-1:0]       z_c;
    logic signed [SW-1:0]       sh_c;
    logic [ZW-1:0]              mag_c;

    // High-pass: subtract the tracked carrier level; forced to 0 while seeding.
    assign avg_c = acc_q[AW-1:DC_SHIFT];
    assign y_c   = seed_q ? '0 : (signed'({1'b0, x_q}) - signed'({1'b0, avg_c}));

    shift_add_mult #(
        .AW(YW),
        .BW(8)
    ) u_mult (
        .clk    (CLK),
        .rst_n  (RSTb),
        .start_i(state_q == ST_DC),
        .a_i    (y_c),
        .b_i    (gain_q),
        .done_c (mult_done_c),
        .prod_o (prod)
    );

    // Q4.4 gain back to unity scale, then output scaling and magnitude.
    assign z_c   = ZW'(prod >>> 4);
    assign sh_c  = SW'(z_c >>> OSH);
    assign mag_c = z_c[ZW-1] ? ZW'(-z_c) : ZW'(z_c);

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        acc_d      = acc_q;
        seed_d     = seed_q;
        s_d        = s_q;
        over_d     = over_q;
        gain_d     = gain_q;
        hold_d     = hold_q;
        audio_d    = audio_q;
        out_tick_d = 1'b0;
        overrun_d  = in_tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (in_tick) begin
                    x_d     = demod_in;
                    state_d = ST_DC;
                end
            end
            ST_DC: begin
                if (seed_q) begin
                    acc_d  = AW'(x_q) << DC_SHIFT;
                    seed_d = 1'b0;
                end else begin
                    acc_d = acc_q + AW'(y_c);
                end
                state_d = ST_MUL;
            end
            ST_MUL: begin
                if (mult_done_c) begin
                    state_d = ST_SAT;
                end
            end
            ST_SAT: begin
                s_d     = BITS_OUT'(sat_clamp(32'(sh_c), BITS_OUT));
                over_d  = 32'(mag_c) > TARGET;
                state_d = ST_AGC;
            end
            ST_AGC: begin
                audio_d    = s_q;
                out_tick_d = 1'b1;
                if (over_q) begin
                    gain_d = (gain_q > GAIN_MIN) ? (gain_q - 8'd1) : GAIN_MIN;
                    hold_d = '0;
                end else if (hold_q == HW'(HOLD_SAMPLES - 1)) begin
                    gain_d = (gain_q < GAIN_MAX) ? (gain_q + 8'd1) : GAIN_MAX;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            acc_q      <= '0;
            seed_q     <= 1'b1;
            s_q        <= '0;
            over_q     <= 1'b0;
            gain_q     <= GAIN_UNITY;
            hold_q     <= '0;
            audio_q    <= '0;
            out_tick_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            seed_q     <= seed_d;
            s_q        <= s_d;
            over_q     <= over_d;
            gain_q     <= gain_d;
            hold_q     <= hold_d;
            audio_q    <= audio_d;
            out_tick_q <= out_tick_d;
            overrun_q  <= overrun_d;
        end
    end

    assign audio_out = audio_q;
    assign out_tick  = out_tick_q;
    assign gain_out  = gain_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_am_audio_agc.sv
// Bench for am_audio_agc: behavioural reference model feeds a scoreboard of
// expected (audio, gain) pairs; each test task compares DUT outputs inline.
module tb_am_audio_agc;

    localparam int HOLD = 4;
    localparam int DCS  = 10;
    localparam int TGT  = 24576;

    logic               CLK;
    logic               RSTb;
    logic [15:0]        demod_in;
    logic               in_tick;
    logic signed [7:0]  audio_out;
    logic               out_tick;
    logic [7:0]         gain_out;
    logic               overrun;

    am_audio_agc #(
        .BITS(16), .BITS_OUT(8), .DC_SHIFT(DCS), .TARGET(TGT), .HOLD_SAMPLES(HOLD)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .demod_in(demod_in), .in_tick(in_tick),
        .audio_out(audio_out), .out_tick(out_tick), .gain_out(gain_out), .overrun(overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int audio;
        int gain;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad = 0;

    longint m_acc;
    bit     m_seed;
    int     m_gain;
    int     m_hold;

    task automatic model_reset();
        m_acc  = 0;
        m_seed = 1'b1;
        m_gain = 16;
        m_hold = 0;
        sbq.delete();
    endtask

    // Reference: integer arithmetic, floor shifts, push (audio, post-update gain).
    task automatic model_push(input int x);
        longint y, z, s, mag;
        exp_t e;
        if (m_seed) begin
            m_acc  = longint'(x) * (longint'(1) << DCS);
            y      = 0;
            m_seed = 1'b0;
        end else begin
            y     = longint'(x) - (m_acc >> DCS);
            m_acc = m_acc + y;
        end
        z   = (y * m_gain) >>> 4;
        s   = z >>> 9;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        mag = (z < 0) ? -z : z;
        if (mag > TGT) begin
            m_gain = (m_gain > 1) ? m_gain - 1 : 1;
            m_hold = 0;
        end else if (m_hold == HOLD - 1) begin
            m_gain = (m_gain < 255) ? m_gain + 1 : 255;
            m_hold = 0;
        end else begin
            m_hold = m_hold + 1;
        end
        e.audio = int'(s);
        e.gain  = m_gain;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTb    = 1'b0;
        in_tick = 1'b0;
        demod_in = '0;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        model_reset();
    endtask

    task automatic send_tick(input int x);
        @(negedge CLK);
        demod_in = 16'(x);
        in_tick  = 1'b1;
        model_push(x);
        @(negedge CLK);
        in_tick = 1'b0;
    endtask

    // Waits for out_tick; lat is the number of edges after the tick edge.
    task automatic wait_out(output int lat, output bit to);
        to  = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            lat++;
            if (out_tick) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_one(input int x, output int a, output int g, output int lat, output bit to);
        send_tick(x);
        wait_out(lat, to);
        a = int'(audio_out);
        g = int'(gain_out);
    endtask

    task automatic test_reset();
        int n_out, n_ovr;
        do_reset();
        n_out = 0;
        n_ovr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (out_tick) n_out++;
            if (overrun)  n_ovr++;
        end
        total++;
        if (audio_out !== 8'sd0) begin bad++; $display("FAIL reset_audio: got %0d want 0", audio_out); end
        total++;
        if (gain_out !== 8'd16) begin bad++; $display("FAIL reset_gain: got %0d want 16", gain_out); end
        total++;
        if (n_out !== 0) begin bad++; $display("FAIL reset_out_tick: got %0d pulses want 0", n_out); end
        total++;
        if (n_ovr !== 0) begin bad++; $display("FAIL reset_overrun: got %0d pulses want 0", n_ovr); end
    endtask

    task automatic test_first_sample();
        int a, g, lat;
        bit to;
        exp_t e;
        do_reset();
        run_one(1000, a, g, lat, to);
        e = sbq.pop_front();
        total++;
        if (to || lat !== 11) begin bad++; $display("FAIL first_latency: got %0d (timeout=%0d) want 11", lat, to); end
        total++;
        if (a !== 0 || a !== e.audio) begin bad++; $display("FAIL first_audio: got %0d want 0", a); end
        total++;
        if (g !== 16 || g !== e.gain) begin bad++; $display("FAIL first_gain: got %0d want 16", g); end
        @(negedge CLK);
        total++;
        if (out_tick !== 1'b0) begin bad++; $display("FAIL first_tick_width: out_tick=%0b want 0", out_tick); end
    endtask

    task automatic test_pos_step();
        int xs[4] = '{10000, 10000, 10000, 35600};
        int a, g, lat;
        bit to;
        exp_t e;
        do_reset();
        foreach (xs[k]) begin
            run_one(xs[k], a, g, lat, to);
            e = sbq.pop_front();
            total++;
            if (to || lat !== 11 || a !== e.audio || g !== e.gain) begin
                bad++;
                $display("FAIL pos_step[%0d]: audio=%0d gain=%0d lat=%0d want audio=%0d gain=%0d lat=11",
                         k, a, g, lat, e.audio, e.gain);
            end
        end
        total++;
        if (a !== 50 || g !== 15) begin bad++; $display("FAIL pos_step_final: audio=%0d gain=%0d want 50/15", a, g); end
    endtask

    task automatic test_neg_step();
        int xs[2] = '{65535, 0};
        int a, g, lat;
        bit to;
        exp_t e;
        do_reset();
        foreach (xs[k]) begin
            run_one(xs[k], a, g, lat, to);
            e = sbq.pop_front();
            total++;
            if (to || a !== e.audio || g !== e.gain) begin
                bad++;
                $display("FAIL neg_step[%0d]: audio=%0d gain=%0d want audio=%0d gain=%0d", k, a, g, e.audio, e.gain);
            end
        end
        total++;
        if (a !== -128 || g !== 15) begin bad++; $display("FAIL neg_step_final: audio=%0d gain=%0d want -128/15", a, g); end
    endtask

    task automatic test_hold();
        int a, g, lat;
        bit to;
        exp_t e;
        int nz;
        do_reset();
        nz = 0;
        for (int k = 1; k <= 8; k++) begin
            run_one(30000, a, g, lat, to);
            e = sbq.pop_front();
            if (to || a !== 0) nz++;
            if (k == 4) begin
                total++;
                if (g !== 17 || g !== e.gain) begin bad++; $display("FAIL hold_gain4: got %0d want 17", g); end
            end
            if (k == 8) begin
                total++;
                if (g !== 18 || g !== e.gain) begin bad++; $display("FAIL hold_gain8: got %0d want 18", g); end
            end
        end
        total++;
        if (nz !== 0) begin bad++; $display("FAIL hold_audio: %0d samples nonzero or missing, want 0", nz); end
    endtask

    task automatic test_overrun();
        int n_out, n_ovr, ovr_at, out_at;
        exp_t e;
        do_reset();
        n_out = 0; n_ovr = 0; ovr_at = -1; out_at = -1;
        @(negedge CLK);
        demod_in = 16'd12345;
        in_tick  = 1'b1;
        model_push(12345);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (out_tick) begin
                n_out++;
                out_at = i;
                e = sbq.pop_front();
                total++;
                if (audio_out !== 8'(e.audio) || gain_out !== 8'(e.gain)) begin
                    bad++;
                    $display("FAIL overrun_data: audio=%0d gain=%0d want %0d/%0d", audio_out, gain_out, e.audio, e.gain);
                end
            end
            if (overrun) begin
                n_ovr++;
                ovr_at = i;
            end
            in_tick  = (i == 4);
            demod_in = (i == 4) ? 16'd50000 : 16'd12345;
        end
        total++;
        if (n_out !== 1 || out_at !== 11) begin bad++; $display("FAIL overrun_out_ticks: got %0d at %0d want 1 at 11", n_out, out_at); end
        total++;
        if (n_ovr !== 1 || ovr_at !== 5) begin bad++; $display("FAIL overrun_pulses: got %0d at %0d want 1 at 5", n_ovr, ovr_at); end
    endtask

    task automatic test_back_to_back();
        int n_out, n_ovr;
        exp_t e;
        do_reset();
        n_out = 0; n_ovr = 0;
        @(negedge CLK);
        demod_in = 16'd20000;
        in_tick  = 1'b1;
        model_push(20000);
        for (int i = 0; i < 35; i++) begin
            @(negedge CLK);
            if (out_tick) begin
                n_out++;
                e = sbq.pop_front();
                total++;
                if (audio_out !== 8'(e.audio) || gain_out !== 8'(e.gain)) begin
                    bad++;
                    $display("FAIL b2b_data[%0d]: audio=%0d gain=%0d want %0d/%0d", n_out, audio_out, gain_out, e.audio, e.gain);
                end
            end
            if (overrun) n_ovr++;
            in_tick = (i == 11);
            if (i == 11) begin
                demod_in = 16'd60000;
                model_push(60000);
            end
        end
        total++;
        if (n_out !== 2) begin bad++; $display("FAIL b2b_out_ticks: got %0d want 2", n_out); end
        total++;
        if (n_ovr !== 0) begin bad++; $display("FAIL b2b_overrun: got %0d want 0", n_ovr); end
    endtask

    task automatic test_reset_mid();
        int xs[4] = '{10000, 10000, 10000, 35600};
        int a, g, lat, n_out;
        bit to;
        exp_t e;
        do_reset();
        foreach (xs[k]) run_one(xs[k], a, g, lat, to);
        sbq.delete();
        total++;
        if (gain_out !== 8'd15 || audio_out !== 8'sd50) begin
            bad++; $display("FAIL rmid_pre: audio=%0d gain=%0d want 50/15", audio_out, gain_out);
        end
        @(negedge CLK);
        demod_in = 16'd40000;
        in_tick  = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
        repeat (4) @(negedge CLK);
        RSTb = 1'b0;
        #1;
        total++;
        if (audio_out !== 8'sd0 || gain_out !== 8'd16 || out_tick !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL rmid_values: audio=%0d gain=%0d tick=%0b ovr=%0b want 0/16/0/0",
                            audio_out, gain_out, out_tick, overrun);
        end
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        model_reset();
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (out_tick) n_out++;
        end
        total++;
        if (n_out !== 0) begin bad++; $display("FAIL rmid_no_tick: got %0d want 0", n_out); end
        run_one(5000, a, g, lat, to);
        e = sbq.pop_front();
        total++;
        if (to || a !== 0 || g !== e.gain) begin bad++; $display("FAIL rmid_reseed: audio=%0d gain=%0d want 0/%0d", a, g, e.gain); end
    endtask

    task automatic test_random();
        int a, g, lat, x;
        bit to;
        exp_t e;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            x = (k % 5 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(20000, 45000));
            run_one(x, a, g, lat, to);
            e = sbq.pop_front();
            total++;
            if (to || lat !== 11 || a !== e.audio || g !== e.gain) begin
                bad++;
                $display("FAIL random[%0d] x=%0d: audio=%0d gain=%0d want %0d/%0d", k, x, a, g, e.audio, e.gain);
            end
        end
    endtask

    initial begin
        RSTb     = 1'b0;
        in_tick  = 1'b0;
        demod_in = '0;
        model_reset();
        test_reset();
        test_first_sample();
        test_pos_step();
        test_neg_step();
        test_hold();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
